// File: rtl/time_uart_reporter.sv
// time_uart_reporter
// Serialises a snapshot of the packed time value into the 13-byte ASCII frame
// "HH:MM:SS.CC\r\n" and feeds it one byte at a time to a UART TX byte port.
// Frames are sent on an explicit request or, while enabled, once per period.
module time_uart_reporter #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_send,
    input  logic        i_auto,
    input  logic [23:0] i_time_data,
    input  logic        i_tx_done,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data,
    output logic        o_busy
);

    localparam int              CW      = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(CLK_FREQ - 1);
    localparam logic [3:0]      IDX_LAST = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Tens digit of a field; fields are at most 7 bits so the quotient fits 4 bits
    // (a centisecond of 127 yields 12, which is printed as 0x3C).
    function automatic logic [3:0] tens_of(input logic [6:0] v);
        logic [6:0] q;
        q = v / 7'd10;
        return q[3:0];
    endfunction

    // Ones digit of a field.
    function automatic logic [3:0] ones_of(input logic [6:0] v);
        logic [6:0] r;
        r = v % 7'd10;
        return r[3:0];
    endfunction

    // Digit value to ASCII, no clamping.
    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    state_t         r_state;
    logic [3:0]     r_idx;
    logic [23:0]    r_snap;
    logic [CW-1:0]  r_cnt;
    logic           r_tx_start;
    logic [7:0]     r_tx_data;
    logic           r_busy;

    state_t         w_state_nx;
    logic [3:0]     w_idx_nx;
    logic [23:0]    w_snap_nx;
    logic [CW-1:0]  w_cnt_nx;
    logic           w_tx_start_nx;
    logic [7:0]     w_tx_data_nx;
    logic           w_busy_nx;
    logic           w_tick;
    logic           w_trigger;
    logic [7:0]     w_char;
    logic [6:0]     w_hour;
    logic [6:0]     w_min;
    logic [6:0]     w_sec;
    logic [6:0]     w_cs;

    assign w_hour = {2'b00, r_snap[23:19]};
    assign w_min  = {1'b0,  r_snap[18:13]};
    assign w_sec  = {1'b0,  r_snap[12:7]};
    assign w_cs   = r_snap[6:0];

    // Auto-report period counter: runs only while enabled, wraps on the tick.
    always_comb begin
        w_tick   = 1'b0;
        w_cnt_nx = r_cnt;
        if (!i_auto) begin
            w_cnt_nx = '0;
        end else if (r_cnt == CNT_MAX) begin
            w_tick   = 1'b1;
            w_cnt_nx = '0;
        end else begin
            w_cnt_nx = r_cnt + CW'(1);
        end
    end

    assign w_trigger = i_send | w_tick;

    // Character selected by the byte index, built only from the snapshot.
    always_comb begin
        w_char = 8'h00;
        case (r_idx)
            4'd0:    w_char = to_ascii(tens_of(w_hour));
            4'd1:    w_char = to_ascii(ones_of(w_hour));
            4'd2:    w_char = 8'h3A;
            4'd3:    w_char = to_ascii(tens_of(w_min));
            4'd4:    w_char = to_ascii(ones_of(w_min));
            4'd5:    w_char = 8'h3A;
            4'd6:    w_char = to_ascii(tens_of(w_sec));
            4'd7:    w_char = to_ascii(ones_of(w_sec));
            4'd8:    w_char = 8'h2E;
            4'd9:    w_char = to_ascii(tens_of(w_cs));
            4'd10:   w_char = to_ascii(ones_of(w_cs));
            4'd11:   w_char = 8'h0D;
            4'd12:   w_char = 8'h0A;
            default: w_char = 8'h00;
        endcase
    end

    // Frame FSM next-state and next-output logic.
    always_comb begin
        w_state_nx    = r_state;
        w_idx_nx      = r_idx;
        w_snap_nx     = r_snap;
        w_tx_start_nx = 1'b0;
        w_tx_data_nx  = r_tx_data;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_snap_nx  = i_time_data;
                    w_idx_nx   = 4'd0;
                    w_state_nx = S_LOAD;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_LOAD: begin
                w_tx_data_nx  = w_char;
                w_tx_start_nx = 1'b1;
                w_state_nx    = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done) begin
                    if (r_idx == IDX_LAST) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_idx_nx   = r_idx + 4'd1;
                        w_state_nx = S_LOAD;
                    end
                end else begin
                    w_state_nx = S_WAIT;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_idx_nx   = 4'd0;
            end
        endcase
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    // State, datapath and registered output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 4'd0;
            r_snap     <= 24'd0;
            r_cnt      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_idx      <= w_idx_nx;
            r_snap     <= w_snap_nx;
            r_cnt      <= w_cnt_nx;
            r_tx_start <= w_tx_start_nx;
            r_tx_data  <= w_tx_data_nx;
            r_busy     <= w_busy_nx;
        end
    end

    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_busy     = r_busy;

endmodule
